// File: rtl/clk_div_monitor_if.sv
// rtl/clk_div_monitor_if.sv - divided-clock input and measurement results of clk_div_monitor
interface clk_div_monitor_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 i_div_clk;
    logic                 i_clr;
    logic [CNT_WIDTH-1:0] o_period;
    logic [CNT_WIDTH-1:0] o_high_time;
    logic                 o_period_valid;
    logic                 o_lock;
    logic                 o_err;
    logic                 o_timeout;

    modport master (
        output i_div_clk, i_clr,
        input  o_period, o_high_time, o_period_valid, o_lock, o_err, o_timeout
    );

    modport slave (
        input  i_div_clk, i_clr,
        output o_period, o_high_time, o_period_valid, o_lock, o_err, o_timeout
    );
endinterface

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - period/lock self-check of a divided clock; CLK_DIV_MON_DUTY_CHECK_EN adds high-time check
module clk_div_monitor #(
    parameter int EXP_RATIO  = 12,
    parameter int CNT_WIDTH  = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    clk_div_monitor_if.slave mon
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] EXP_P   = CNT_WIDTH'(EXP_RATIO);
    localparam logic [3:0]           LOCK_N  = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    state_t               state;
    logic                 s1, s2, s3;
    logic                 rise;
    logic [CNT_WIDTH-1:0] pcnt;
    logic                 to_seen;
    logic                 timeout_evt;
    logic [3:0]           mcnt;
    logic                 match;
    logic [CNT_WIDTH-1:0] period_q;
    logic [CNT_WIDTH-1:0] high_q;
    logic                 valid_q, lock_q, err_q, timeout_q;

    assign rise = s2 & ~s3;
    // to_seen keeps a saturated counter from reporting the same stall every cycle
    assign timeout_evt = (pcnt == CNT_MAX) && !rise && !to_seen;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            pcnt    <= '0;
            to_seen <= 1'b0;
        end else begin
            s1 <= mon.i_div_clk;
            s2 <= s1;
            s3 <= s2;
            if (rise) begin
                pcnt    <= CNT_ONE;
                to_seen <= 1'b0;
            end else begin
                if (pcnt != CNT_MAX)
                    pcnt <= pcnt + CNT_ONE;
                if (timeout_evt)
                    to_seen <= 1'b1;
            end
        end
    end

`ifdef CLK_DIV_MON_DUTY_CHECK_EN
    logic                 fall;
    logic [CNT_WIDTH-1:0] hcnt;
    logic                 h_fresh;

    assign fall = ~s2 & s3;
    // a high time not refreshed since the last rise is stale and never matches
    assign match = (pcnt == EXP_P) && h_fresh && (high_q == (EXP_P >> 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hcnt    <= '0;
            high_q  <= '0;
            h_fresh <= 1'b0;
        end else begin
            if (rise) begin
                hcnt    <= CNT_ONE;
                h_fresh <= 1'b0;
            end else if (s2 && hcnt != CNT_MAX) begin
                hcnt <= hcnt + CNT_ONE;
            end
            if (fall) begin
                high_q  <= hcnt;
                h_fresh <= 1'b1;
            end
        end
    end
`else
    assign high_q = '0;
    assign match  = (pcnt == EXP_P);
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            mcnt      <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            lock_q    <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= timeout_evt;
            if (mon.i_clr) begin
                state  <= IDLE;
                lock_q <= 1'b0;
                err_q  <= 1'b0;
                mcnt   <= '0;
            end else if (rise) begin
                case (state)
                    IDLE: state <= MEASURE;
                    MEASURE: begin
                        period_q <= pcnt;
                        valid_q  <= 1'b1;
                        if (match) begin
                            mcnt <= mcnt + 4'd1;
                            if (mcnt + 4'd1 == LOCK_N) begin
                                state  <= LOCKED;
                                lock_q <= 1'b1;
                            end
                        end else begin
                            mcnt <= '0;
                        end
                    end
                    LOCKED: begin
                        period_q <= pcnt;
                        valid_q  <= 1'b1;
                        if (!match) begin
                            lock_q <= 1'b0;
                            err_q  <= 1'b1;
                            mcnt   <= '0;
                            state  <= MEASURE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (timeout_evt) begin
                if (state == LOCKED)
                    err_q <= 1'b1;
                lock_q <= 1'b0;
                mcnt   <= '0;
                state  <= IDLE;
            end
        end
    end

    assign mon.o_period       = period_q;
    assign mon.o_high_time    = high_q;
    assign mon.o_period_valid = valid_q;
    assign mon.o_lock         = lock_q;
    assign mon.o_err          = err_q;
    assign mon.o_timeout      = timeout_q;
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - directed self-checking bench for clk_div_monitor
module tb_clk_div_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

`ifdef CLK_DIV_MON_DUTY_CHECK_EN
    localparam int DUTY = 1;
`else
    localparam int DUTY = 0;
`endif

    clk_div_monitor_if #(.CNT_WIDTH(8)) mon_if ();

    clk_div_monitor #(
        .EXP_RATIO (12),
        .CNT_WIDTH (8),
        .LOCK_COUNT(4)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .mon    (mon_if)
    );

    always #5 clk = ~clk;

    // record every valid pulse and timeout seen on the falling edge
    int   cyc = 0;
    int   to_count = 0;
    int   to_cyc = 0;
    int   last_valid_cyc = 0;
    logic [7:0] q_period[$];
    logic       q_lock[$];
    logic       q_err[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst && mon_if.o_period_valid) begin
            q_period.push_back(mon_if.o_period);
            q_lock.push_back(mon_if.o_lock);
            q_err.push_back(mon_if.o_err);
            last_valid_cyc <= cyc;
        end
        if (!rst && mon_if.o_timeout) begin
            to_count <= to_count + 1;
            to_cyc   <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            mon_if.i_div_clk = 1'b1;
            repeat (hi) @(negedge clk);
            mon_if.i_div_clk = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    initial begin
        int b;
        int base_to;
        mon_if.i_div_clk = 1'b0;
        mon_if.i_clr     = 1'b0;
        rst              = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_period", mon_if.o_period, 0);
        check("rst_high", mon_if.o_high_time, 0);
        check("rst_valid", mon_if.o_period_valid, 0);
        check("rst_lock", mon_if.o_lock, 0);
        check("rst_err", mon_if.o_err, 0);
        check("rst_timeout", mon_if.o_timeout, 0);
        rst = 1'b0;
        @(negedge clk);

        // divide by 12, 50% duty
        b = q_period.size();
        drive(6, 6, 6);
        check("d12_count", q_period.size() - b, 5);
        for (int k = 0; k < 5; k++) check("d12_period", q_period[b+k], 12);
        check("d12_lock_rise4", q_lock[b+2], 0);
        check("d12_lock_rise5", q_lock[b+3], 1);
        check("d12_high", mon_if.o_high_time, 6 * DUTY);
        check("d12_lock_now", mon_if.o_lock, 1);
        check("d12_err", mon_if.o_err, 0);

        // switch to divide by 10 while locked
        b = q_period.size();
        drive(5, 5, 6);
        check("d10_count", q_period.size() - b, 6);
        check("d10_first_period", q_period[b], 12);
        check("d10_first_lock", q_lock[b], 1);
        check("d10_first_err", q_err[b], 0);
        check("d10_fail_period", q_period[b+1], 10);
        check("d10_fail_lock", q_lock[b+1], 0);
        check("d10_fail_err", q_err[b+1], 1);
        check("d10_last_period", q_period[b+5], 10);
        check("d10_last_lock", q_lock[b+5], 0);
        check("d10_err_sticky", mon_if.o_err, 1);
        check("d10_high", mon_if.o_high_time, 5 * DUTY);

        // clear, then relock
        mon_if.i_clr = 1'b1;
        @(negedge clk);
        mon_if.i_clr = 1'b0;
        check("clr_err", mon_if.o_err, 0);
        check("clr_lock", mon_if.o_lock, 0);
        check("clr_period_kept", mon_if.o_period, 10);
        b = q_period.size();
        drive(6, 6, 6);
        check("clr_relock_count", q_period.size() - b, 5);
        check("clr_relock_rise4", q_lock[b+2], 0);
        check("clr_relock_rise5", q_lock[b+3], 1);

        // stuck-low input while locked
        base_to = to_count;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (to_count != base_to) break;
        end
        check("to_seen", to_count - base_to, 1);
        check("to_delay", to_cyc - last_valid_cyc, 255);
        check("to_err", mon_if.o_err, 1);
        check("to_lock", mon_if.o_lock, 0);
        repeat (20) @(negedge clk);
        check("to_once", to_count - base_to, 1);
        b = q_period.size();
        drive(6, 6, 6);
        check("to_relock_count", q_period.size() - b, 5);
        check("to_relock_rise4", q_lock[b+2], 0);
        check("to_relock_rise5", q_lock[b+3], 1);
        check("to_err_kept", mon_if.o_err, 1);

        // clear coincident with a detected rise (third posedge after going high)
        b = q_period.size();
        mon_if.i_div_clk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mon_if.i_clr = 1'b1;
        @(negedge clk);
        mon_if.i_clr = 1'b0;
        check("clrrise_valid", mon_if.o_period_valid, 0);
        check("clrrise_err", mon_if.o_err, 0);
        check("clrrise_lock", mon_if.o_lock, 0);
        repeat (3) @(negedge clk);
        mon_if.i_div_clk = 1'b0;
        repeat (6) @(negedge clk);
        check("clrrise_no_publish", q_period.size() - b, 0);
        drive(6, 6, 6);
        check("clrrise_count", q_period.size() - b, 5);
        check("clrrise_rise4", q_lock[b+2], 0);
        check("clrrise_rise5", q_lock[b+3], 1);

        // asynchronous reset mid-period while locked
        check("rst_pre_lock", mon_if.o_lock, 1);
        mon_if.i_div_clk = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_period", mon_if.o_period, 0);
        check("arst_lock", mon_if.o_lock, 0);
        check("arst_valid", mon_if.o_period_valid, 0);
        check("arst_err", mon_if.o_err, 0);
        check("arst_high", mon_if.o_high_time, 0);
        @(negedge clk);
        mon_if.i_div_clk = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // divide by 12 with 7-high/5-low after reset
        b = q_period.size();
        drive(7, 5, 7);
        check("d75_count", q_period.size() - b, 6);
        for (int k = 0; k < 6; k++) check("d75_period", q_period[b+k], 12);
        check("d75_high", mon_if.o_high_time, 7 * DUTY);
        check("d75_rise4", q_lock[b+2], 0);
        check("d75_rise5", q_lock[b+3], 1 - DUTY);
        check("d75_lock_now", mon_if.o_lock, 1 - DUTY);
        check("d75_err", mon_if.o_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
